jt053247_draw: RTL and testbench
================================

Name: jt053247_draw

Overview:
- Sprite line drawer. Responder end of the object scanner's `dr_start`/`dr_busy` handshake.
- Per request it fetches one 16-pixel, 4bpp tile row from graphics ROM as two 32-bit words.
- It applies horizontal zoom and flip, and writes non-transparent pixels into the line buffer.
- Sits between the scanner and the line buffer / ROM arbiter, in place of the 051937-side drawing logic.

Parameters:
- HZ_FRAC, 6, fractional bits of the zoom accumulator; unity step = 1<<HZ_FRAC = 12'h40.
- MAXPX, 256, maximum output pixels written per request (runaway guard).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- dr_start  in  1  one-cycle draw request from scanner
- dr_busy  out  1  drawer occupied; scanner must not pulse `dr_start` while high
- code  in  16  tile code
- attr  in  10  palette/priority attribute, copied to buffer data
- hflip  in  1  horizontal flip
- vflip  in  1  vertical flip
- hpos  in  9  first output pixel x (used only when `hz_keep`=0)
- ysub  in  4  tile row before flip
- hzoom  in  12  source-pixel step per output pixel, unsigned
- hz_keep  in  1  continuation tile of the same sprite
- rom_addr  out  21  word address {code, row, half}
- rom_cs  out  1  ROM request
- rom_ok  in  1  `rom_data` valid for current `rom_addr`
- rom_data  in  32  8 pixels; pixel 0 in [31:28], pixel 7 in [3:0]
- buf_we  out  1  line-buffer write strobe
- buf_addr  out  9  line-buffer x
- buf_din  out  14  {attr, pixel}

Behaviour:
- Reset (`rst_n` low, asynchronous):
  - FSM to IDLE.
  - `dr_busy`, `rom_cs`, `buf_we` = 0; `rom_addr`, `buf_addr`, `buf_din` = 0.
  - Internal acc = 0, nxt_x = 0.
  - Reset mid-draw aborts immediately; no further writes occur.
- Latch: `dr_start` in IDLE latches all inputs on that edge and sets `dr_busy`=1 on the same edge.
  - `dr_start` while busy is ignored; inputs are not re-latched.
- Derived values at latch:
  - row = ysub ^ {4{vflip}}.
  - step = (hzoom==0) ? 12'h40 : hzoom.
  - `hz_keep`=0: x = hpos, acc = 0.
  - `hz_keep`=1: x = nxt_x, acc = residual acc from the previous request; `hpos` ignored.
- States:
  - IDLE: wait for `dr_start`, then go to FETCH0.
  - FETCH0: `rom_cs`=1, `rom_addr`={code,row,1'b0}. Hold until `rom_ok` is sampled high, then store `rom_data` as pixels 0–7 and go to FETCH1.
  - FETCH1: same with half=1, storing pixels 8–15. `rom_cs` stays high across FETCH0→FETCH1; drop it on the cycle after the second `rom_ok`. Go to DRAW.
  - DRAW, one output pixel per clock:
    - src = acc[HZ_FRAC+3:HZ_FRAC].
    - End condition: acc ≥ 16<<HZ_FRAC, or MAXPX pixels emitted. Go to IDLE and clear `dr_busy` on that edge.
    - Otherwise: idx = hflip ? 15−src : src; pix = buffer[idx].
    - `buf_we` = (pix≠0); `buf_addr` = x; `buf_din` = {attr, pix}.
    - Then x = x+1 (mod 512), acc = acc+step.
- Registered outputs: `buf_*` are registered and valid the cycle they are asserted.
- Residual at DRAW exit: acc − (16<<HZ_FRAC) and nxt_x = x are kept for the next `hz_keep` request.
  - MAXPX exit stores residual 0.
- Accumulator width ≥ 13 bits plus 1 guard bit, so step 12'hFFF cannot overflow before the exit check.
- x wraps 511→0 silently; writes continue.
- `rom_ok` may stay high for consecutive cycles: FETCH0 consumes one cycle of it, FETCH1 requires `rom_ok` sampled after `rom_addr` changed.
- Latency: request with `rom_ok` tied high → first `buf_we` at cycle 4 after `dr_start`. Unity zoom → `dr_busy` low after 16 DRAW cycles.

Test Plan:
- Unity zoom, no flip:
  - Stimulus: `code`=16'h0123, `ysub`=3, `hpos`=100, `rom_data` words 32'h12345678 / 32'h9ABCDEF0, `rom_ok` tied high.
  - Required: `rom_addr` = {16'h0123,4'd3,0} then {…,1}; 15 writes at x=100..114 with pixels 1..F; x=115 (pixel 0) not written; `dr_busy` clears after the 16th DRAW cycle.
- `hflip`=1 and `vflip`=1, `ysub`=3, same ROM data → `rom_addr` row=12; first write x=100 pixel... x=100 has pixel 0 (skipped); x=101..115 carry F..1.
- 2× enlarge, `hzoom`=12'h20 → 32 DRAW cycles; x=100,101 both carry pixel 1; final writes x=128..129 carry F; x=130..131 carry pixel 0 and are not written.
- Continuation with reduction:
  - Stimulus: `hzoom`=12'h60, first tile `hpos`=500, then second request with `hz_keep`=1 and `hpos`=0.
  - Required: first tile writes 11 pixels wrapping 500..510 at most 511→0 per source indices 0,1,3,4,6,7,9,10,12,13,15; second tile starts at nxt_x=511−... the stored nxt_x, with acc = stored residual (12'h020), not at x=0.
- Handshake/ROM stall:
  - Stimulus: `rom_ok` low for 5 cycles in each fetch; pulse `dr_start` again while busy.
  - Required: `rom_cs` held, no `buf_we` before both words arrive; second pulse ignored, `code` unchanged.
- Reset abort: drop `rst_n` in DRAW after 3 writes → `buf_we`, `dr_busy`, `rom_cs` low immediately; after release, a new request draws normally with acc=0.

Source files
------------

// File: rtl/jt053247_draw.sv
// Sprite line drawer: fetches one 16-pixel 4bpp tile row from ROM, applies
// horizontal zoom/flip and writes the opaque pixels into the line buffer.
module jt053247_draw #(
  parameter int HZ_FRAC = 6,
  parameter int MAXPX   = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dr_start,
  output logic        dr_busy,
  input  logic [15:0] code,
  input  logic [9:0]  attr,
  input  logic        hflip,
  input  logic        vflip,
  input  logic [8:0]  hpos,
  input  logic [3:0]  ysub,
  input  logic [11:0] hzoom,
  input  logic        hz_keep,
  output logic [20:0] rom_addr,
  output logic        rom_cs,
  input  logic        rom_ok,
  input  logic [31:0] rom_data,
  output logic        buf_we,
  output logic [8:0]  buf_addr,
  output logic [13:0] buf_din
);

  // Accumulator holds up to (16<<HZ_FRAC)-1 plus a full 12-bit step, plus a guard bit.
  localparam int AW = HZ_FRAC + 8;
  localparam int CW = $clog2(MAXPX + 1);
  localparam logic [AW-1:0] LIMIT = AW'(16 << HZ_FRAC);
  localparam logic [11:0]   UNITY = 12'(1 << HZ_FRAC);

  typedef enum logic [1:0] {IDLE, FETCH0, FETCH1, DRAW} state_t;

  state_t         state, state_nxt;
  logic [9:0]     attr_l;
  logic           hflip_l;
  logic [11:0]    step_l;
  logic [8:0]     x, nxt_x;
  logic [AW-1:0]  acc;
  logic [CW-1:0]  cnt;
  logic [63:0]    pix_row;

  logic [3:0]     src, sel, pix;
  logic [AW-1:0]  acc_sum, acc_res;
  logic [8:0]     nxt_x_res;
  logic           over, sum_over, cnt_last, emit, draw_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dr_start)  state_nxt = FETCH0;
      FETCH0:  if (rom_ok)    state_nxt = FETCH1;
      FETCH1:  if (rom_ok)    state_nxt = DRAW;
      DRAW:    if (draw_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Draw decisions: the exit is looked ahead by one step so the last opaque
  // pixel and the busy drop share an edge.
  always_comb begin
    src       = acc[HZ_FRAC+3:HZ_FRAC];
    sel       = hflip_l ? src : ~src;
    pix       = pix_row[{sel, 2'b00} +: 4];
    acc_sum   = acc + AW'(step_l);
    over      = acc >= LIMIT;
    sum_over  = acc_sum >= LIMIT;
    cnt_last  = cnt == CW'(MAXPX - 1);
    emit      = (state == DRAW) && !over;
    draw_done = over || sum_over || cnt_last;
    acc_res   = '0;
    nxt_x_res = x + 9'd1;
    if (over) begin
      acc_res   = acc - LIMIT;
      nxt_x_res = x;
    end else if (sum_over) begin
      acc_res   = acc_sum - LIMIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dr_busy  <= 1'b0;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      buf_we   <= 1'b0;
      buf_addr <= '0;
      buf_din  <= '0;
      attr_l   <= '0;
      hflip_l  <= 1'b0;
      step_l   <= '0;
      x        <= '0;
      nxt_x    <= '0;
      acc      <= '0;
      cnt      <= '0;
      pix_row  <= '0;
    end else begin
      buf_we <= 1'b0;
      case (state)
        IDLE: if (dr_start) begin
          dr_busy  <= 1'b1;
          rom_cs   <= 1'b1;
          rom_addr <= {code, ysub ^ {4{vflip}}, 1'b0};
          attr_l   <= attr;
          hflip_l  <= hflip;
          step_l   <= (hzoom == 12'd0) ? UNITY : hzoom;
          cnt      <= '0;
          // A continuation tile resumes where the previous one left off.
          x        <= hz_keep ? nxt_x : hpos;
          if (!hz_keep) acc <= '0;
        end
        FETCH0: if (rom_ok) begin
          pix_row[63:32] <= rom_data;
          rom_addr[0]    <= 1'b1;
        end
        FETCH1: if (rom_ok) begin
          pix_row[31:0] <= rom_data;
          rom_cs        <= 1'b0;
        end
        DRAW: begin
          if (emit) begin
            buf_we   <= pix != 4'd0;
            buf_addr <= x;
            buf_din  <= {attr_l, pix};
            x        <= x + 9'd1;
            cnt      <= cnt + CW'(1);
            acc      <= acc_sum;
          end
          if (draw_done) begin
            dr_busy <= 1'b0;
            acc     <= acc_res;
            nxt_x   <= nxt_x_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jt053247_draw.sv
// Self-checking bench for jt053247_draw: directed scenarios plus random
// requests checked against a per-pixel loop model of the zoom/flip rules.
module tb_jt053247_draw;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dr_start = 1'b0;
  logic        dr_busy;
  logic [15:0] code = '0;
  logic [9:0]  attr = '0;
  logic        hflip = 1'b0, vflip = 1'b0, hz_keep = 1'b0;
  logic [8:0]  hpos = '0;
  logic [3:0]  ysub = '0;
  logic [11:0] hzoom = '0;
  logic [20:0] rom_addr;
  logic        rom_cs, rom_ok;
  logic [31:0] rom_data;
  logic        buf_we;
  logic [8:0]  buf_addr;
  logic [13:0] buf_din;

  logic [31:0] w0 = '0, w1 = '0;
  logic        ok_force = 1'b1, ok_rand_en = 1'b0, ok_rand = 1'b1;
  logic        collect = 1'b0;

  logic [22:0] wr_q[$];
  logic [22:0] exp_wr[$];
  logic [20:0] ra_q[$];
  int          m_acc = 0, m_nxt_x = 0, exp_n = 0;
  int          busy_cycles, first_we;
  int          n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  assign rom_ok   = ok_rand_en ? ok_rand : ok_force;
  assign rom_data = rom_addr[0] ? w1 : w0;

  always @(posedge clk) begin
    #2 ok_rand = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (collect) begin
      if (buf_we) wr_q.push_back({buf_addr, buf_din});
      if (rom_cs && rom_ok) ra_q.push_back(rom_addr);
    end
  end

  jt053247_draw dut (
    .clk(clk), .rst_n(rst_n), .dr_start(dr_start), .dr_busy(dr_busy),
    .code(code), .attr(attr), .hflip(hflip), .vflip(vflip), .hpos(hpos),
    .ysub(ysub), .hzoom(hzoom), .hz_keep(hz_keep),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_din(buf_din)
  );

  // Reference: walk output pixels with a plain integer accumulator.
  function automatic void model_run(input logic [9:0] a, input logic hf, input logic [8:0] hp,
                                    input logic [11:0] hz, input logic keep, input logic [63:0] row);
    int step, acc, x, n, src, idx;
    logic [3:0] p;
    step = (hz == 12'd0) ? 64 : int'(hz);
    acc  = keep ? m_acc : 0;
    x    = keep ? m_nxt_x : int'(hp);
    n    = 0;
    exp_wr.delete();
    while (acc < 1024 && n < 256) begin
      src = acc / 64;
      idx = hf ? 15 - src : src;
      p   = row[63 - 4*idx -: 4];
      if (p != 4'd0) exp_wr.push_back({9'(x), a, p});
      x   = (x + 1) % 512;
      acc = acc + step;
      n++;
    end
    m_acc   = (acc >= 1024) ? acc - 1024 : 0;
    m_nxt_x = x;
    exp_n   = n;
  endfunction

  function automatic int wr_mismatch();
    if (wr_q.size() != exp_wr.size()) return 1;
    foreach (wr_q[i]) if (wr_q[i] !== exp_wr[i]) return 1;
    return 0;
  endfunction

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    for (int k = 1; k <= 4000; k++) begin
      if (buf_we && first_we < 0) first_we = k;
      if (!dr_busy) begin
        done = 1'b1;
        break;
      end
      busy_cycles++;
      @(negedge clk);
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_timeout: dr_busy still 1, required 0 within 4000 cycles", tag);
    end
    @(negedge clk);
    @(negedge clk);
    collect = 1'b0;
  endtask

  task automatic run_req(input string tag, input logic [15:0] c, input logic [9:0] a,
                         input logic hf, input logic vf, input logic [8:0] hp,
                         input logic [3:0] ys, input logic [11:0] hz, input logic keep);
    model_run(a, hf, hp, hz, keep, {w0, w1});
    @(negedge clk);
    code = c; attr = a; hflip = hf; vflip = vf; hpos = hp; ysub = ys; hzoom = hz; hz_keep = keep;
    wr_q.delete(); ra_q.delete(); collect = 1'b1;
    dr_start = 1'b1;
    @(negedge clk);
    dr_start = 1'b0;
    busy_cycles = 0;
    first_we = -1;
    wait_idle(tag);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({dr_busy, rom_cs, buf_we} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy/cs/we=%b required 000", {dr_busy, rom_cs, buf_we});
    end
    n_checks++;
    if (rom_addr !== 21'd0 || buf_addr !== 9'd0 || buf_din !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_data: rom_addr=%h buf_addr=%h buf_din=%h required 0", rom_addr, buf_addr, buf_din);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unity();
    w0 = 32'h12345678; w1 = 32'h9ABCDEF0;
    run_req("unity", 16'h0123, 10'h155, 1'b0, 1'b0, 9'd100, 4'd3, 12'h040, 1'b0);
    n_checks++;
    if (ra_q.size() != 2 || ra_q[0] !== {16'h0123, 4'd3, 1'b0} || ra_q[1] !== {16'h0123, 4'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL unity_rom_addr: got %0d fetches first=%h, required 2 fetches %h/%h",
               ra_q.size(), ra_q.size() > 0 ? ra_q[0] : 21'd0, {16'h0123, 4'd3, 1'b0}, {16'h0123, 4'd3, 1'b1});
    end
    n_checks++;
    if (wr_q.size() != 15 || wr_q[0] !== {9'd100, 10'h155, 4'h1} || wr_q[14] !== {9'd114, 10'h155, 4'hF}) begin
      n_fail++;
      $display("FAIL unity_writes: got %0d writes, required 15 at x=100..114 pixels 1..F", wr_q.size());
    end
    n_checks++;
    if (wr_mismatch() != 0) begin
      n_fail++;
      $display("FAIL unity_model: got %0d writes, required %0d", wr_q.size(), exp_wr.size());
    end
    n_checks++;
    if (busy_cycles != 18) begin
      n_fail++;
      $display("FAIL unity_busy: busy %0d cycles, required 18", busy_cycles);
    end
    n_checks++;
    if (first_we != 4) begin
      n_fail++;
      $display("FAIL unity_latency: first buf_we at cycle %0d, required 4", first_we);
    end
  endtask

  task automatic test_flip();
    run_req("flip", 16'h0123, 10'h2AA, 1'b1, 1'b1, 9'd100, 4'd3, 12'h040, 1'b0);
    n_checks++;
    if (ra_q.size() != 2 || ra_q[0] !== {16'h0123, 4'd12, 1'b0}) begin
      n_fail++;
      $display("FAIL flip_rom_addr: got %h, required %h", ra_q.size() > 0 ? ra_q[0] : 21'd0, {16'h0123, 4'd12, 1'b0});
    end
    n_checks++;
    if (wr_q.size() != 15 || wr_q[0] !== {9'd101, 10'h2AA, 4'hF} || wr_q[14] !== {9'd115, 10'h2AA, 4'h1}) begin
      n_fail++;
      $display("FAIL flip_writes: got %0d writes first=%h, required 15 at x=101..115 pixels F..1",
               wr_q.size(), wr_q.size() > 0 ? wr_q[0] : 23'd0);
    end
    n_checks++;
    if (wr_mismatch() != 0) begin
      n_fail++;
      $display("FAIL flip_model: got %0d writes, required %0d", wr_q.size(), exp_wr.size());
    end
  endtask

  task automatic test_zoom2();
    run_req("zoom2", 16'h0123, 10'h001, 1'b0, 1'b0, 9'd100, 4'd3, 12'h020, 1'b0);
    n_checks++;
    if (busy_cycles != 34) begin
      n_fail++;
      $display("FAIL zoom2_busy: busy %0d cycles, required 34", busy_cycles);
    end
    n_checks++;
    if (wr_q.size() != 30 || wr_q[0] !== {9'd100, 10'h001, 4'h1} || wr_q[1] !== {9'd101, 10'h001, 4'h1}
        || wr_q[28] !== {9'd128, 10'h001, 4'hF} || wr_q[29] !== {9'd129, 10'h001, 4'hF}) begin
      n_fail++;
      $display("FAIL zoom2_writes: got %0d writes, required 30 (x=100,101 pixel 1; x=128,129 pixel F)", wr_q.size());
    end
    n_checks++;
    if (wr_mismatch() != 0) begin
      n_fail++;
      $display("FAIL zoom2_model: got %0d writes, required %0d", wr_q.size(), exp_wr.size());
    end
  endtask

  task automatic test_continuation();
    run_req("cont1", 16'h0040, 10'h0F0, 1'b0, 1'b0, 9'd500, 4'd0, 12'h060, 1'b0);
    n_checks++;
    if (wr_q.size() != 10 || wr_q[0] !== {9'd500, 10'h0F0, 4'h1} || wr_q[9] !== {9'd509, 10'h0F0, 4'hE}) begin
      n_fail++;
      $display("FAIL cont1_writes: got %0d writes, required 10 at x=500..509", wr_q.size());
    end
    n_checks++;
    if (m_acc != 32 || m_nxt_x != 511 || wr_mismatch() != 0) begin
      n_fail++;
      $display("FAIL cont1_model: got %0d writes residual=%0d nxt_x=%0d, required %0d writes residual 32 nxt_x 511",
               wr_q.size(), m_acc, m_nxt_x, exp_wr.size());
    end
    run_req("cont2", 16'h0040, 10'h0F0, 1'b0, 1'b0, 9'd0, 4'd0, 12'h060, 1'b1);
    n_checks++;
    if (wr_q.size() != 10 || wr_q[0] !== {9'd511, 10'h0F0, 4'h1} || wr_q[1] !== {9'd0, 10'h0F0, 4'h3}) begin
      n_fail++;
      $display("FAIL cont2_writes: got %0d writes first=%h, required 10 starting x=511 pixel 1 then x=0 pixel 3",
               wr_q.size(), wr_q.size() > 0 ? wr_q[0] : 23'd0);
    end
    n_checks++;
    if (wr_mismatch() != 0) begin
      n_fail++;
      $display("FAIL cont2_model: got %0d writes, required %0d", wr_q.size(), exp_wr.size());
    end
  endtask

  task automatic test_stall();
    w0 = 32'h12345678; w1 = 32'h9ABCDEF0;
    model_run(10'h0C3, 1'b0, 9'd50, 12'h040, 1'b0, {w0, w1});
    @(negedge clk);
    code = 16'h0A5A; attr = 10'h0C3; hflip = 0; vflip = 0; hpos = 9'd50; ysub = 4'd5; hzoom = 12'h040; hz_keep = 0;
    wr_q.delete(); ra_q.delete(); collect = 1'b1;
    ok_force = 1'b0;
    dr_start = 1'b1;
    @(negedge clk);
    dr_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (rom_cs !== 1'b1 || buf_we !== 1'b0) begin
        n_fail++;
        $display("FAIL stall0_hold: rom_cs=%b buf_we=%b, required 1/0", rom_cs, buf_we);
      end
      if (k == 4) ok_force = 1'b1;
      @(negedge clk);
    end
    ok_force = 1'b0;
    code = 16'hBEEF;
    dr_start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (rom_cs !== 1'b1 || buf_we !== 1'b0 || dr_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL stall1_hold: rom_cs=%b buf_we=%b busy=%b, required 1/0/1", rom_cs, buf_we, dr_busy);
      end
      if (k == 4) ok_force = 1'b1;
      @(negedge clk);
      if (k == 0) dr_start = 1'b0;
    end
    busy_cycles = 0;
    first_we = -1;
    wait_idle("stall");
    n_checks++;
    if (ra_q.size() != 2 || ra_q[0] !== {16'h0A5A, 4'd5, 1'b0} || ra_q[1] !== {16'h0A5A, 4'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL stall_rom_addr: got %0d fetches last=%h, required 2 with code 0A5A",
               ra_q.size(), ra_q.size() > 0 ? ra_q[ra_q.size()-1] : 21'd0);
    end
    n_checks++;
    if (wr_mismatch() != 0 || dr_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_writes: got %0d writes busy=%b, required %0d writes busy 0", wr_q.size(), dr_busy, exp_wr.size());
    end
  endtask

  task automatic test_reset_abort();
    logic seen;
    w0 = 32'h11111111; w1 = 32'h11111111;
    @(negedge clk);
    code = 16'h0777; attr = 10'h3FF; hflip = 0; vflip = 0; hpos = 9'd20; ysub = 4'd1; hzoom = 12'h040; hz_keep = 0;
    wr_q.delete(); ra_q.delete(); collect = 1'b1;
    dr_start = 1'b1;
    @(negedge clk);
    dr_start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (wr_q.size() >= 3) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL abort_start: got %0d writes, required 3 within 40 cycles", wr_q.size());
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({buf_we, dr_busy, rom_cs} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_outputs: we/busy/cs=%b, required 000", {buf_we, dr_busy, rom_cs});
    end
    @(negedge clk);
    rst_n = 1'b1;
    collect = 1'b0;
    m_acc = 0;
    m_nxt_x = 0;
    run_req("after_abort", 16'h0777, 10'h3FF, 1'b0, 1'b0, 9'd300, 4'd1, 12'h040, 1'b1);
    n_checks++;
    if (wr_q.size() != 16 || wr_q[0] !== {9'd0, 10'h3FF, 4'h1} || wr_mismatch() != 0) begin
      n_fail++;
      $display("FAIL after_abort: got %0d writes first=%h, required 16 starting x=0",
               wr_q.size(), wr_q.size() > 0 ? wr_q[0] : 23'd0);
    end
  endtask

  task automatic test_random();
    logic [15:0] c;
    logic [3:0]  ys;
    logic        vf;
    logic [11:0] hz;
    ok_rand_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      c  = 16'($urandom);
      ys = 4'($urandom);
      vf = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       hz = 12'd0;
        1:       hz = 12'($urandom_range(1, 63));
        2:       hz = 12'($urandom_range(64, 255));
        default: hz = 12'($urandom);
      endcase
      w0 = $urandom; w1 = $urandom;
      run_req("random", c, 10'($urandom), 1'($urandom), vf, 9'($urandom), ys, hz, 1'($urandom));
      n_checks++;
      if (ra_q.size() != 2 || ra_q[0] !== {c, ys ^ {4{vf}}, 1'b0} || ra_q[1] !== {c, ys ^ {4{vf}}, 1'b1}) begin
        n_fail++;
        $display("FAIL random_rom_addr[%0d]: got %0d fetches first=%h, required %h",
                 i, ra_q.size(), ra_q.size() > 0 ? ra_q[0] : 21'd0, {c, ys ^ {4{vf}}, 1'b0});
      end
      n_checks++;
      if (wr_mismatch() != 0) begin
        n_fail++;
        $display("FAIL random_writes[%0d]: hzoom=%h got %0d writes, required %0d", i, hz, wr_q.size(), exp_wr.size());
      end
    end
    ok_rand_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unity();
    test_flip();
    test_zoom2();
    test_continuation();
    test_stall();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
